// File: rtl/chk_sum_pkg.sv
// Shared types, constants and arithmetic for the RFC 1071 checksum sequencer.
// Optional build macro used by the top: CHK_SUM_CTRL_VERIFY_EN.
package chk_sum_pkg;

  localparam int unsigned CHK_W = 16;
  localparam logic [7:0]  PAD_BYTE = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One end-around carry suffices: a+b <= 0x1FFFE, so the re-add cannot carry again.
  function automatic logic [CHK_W-1:0] fold(input logic [CHK_W-1:0] a,
                                            input logic [CHK_W-1:0] b);
    logic [CHK_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CHK_W-1:0] + {{(CHK_W-1){1'b0}}, s[CHK_W]};
  endfunction

endpackage

// File: rtl/chk_sum_acc.sv
// 16-bit one's-complement accumulator: clear, load(seed) and add(word) with end-around carry.
module chk_sum_acc
  import chk_sum_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CHK_W-1:0] i_seed,
  input  logic             i_add,
  input  logic [CHK_W-1:0] i_word,
  output logic [CHK_W-1:0] o_acc
);

  logic [CHK_W-1:0] r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_seed;
    end else if (i_add) begin
      r_acc <= fold(r_acc, i_word);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/chk_sum_ctrl.sv
// Checksum sequencer: byte packer, FSM, saturating byte counter and result port.
// Defining CHK_SUM_CTRL_VERIFY_EN adds the res_ok port (received-checksum verify).
module chk_sum_ctrl
  import chk_sum_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  input  logic [CHK_W-1:0] init_val,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CHK_W-1:0] res_chk,
  output logic [LEN_W-1:0] res_len,
  output logic             res_ovf,
`ifdef CHK_SUM_CTRL_VERIFY_EN
  output logic             res_ok,
`endif
  output logic             busy
);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_run;
  logic [7:0]       r_hi;
  logic             r_hi_vld;
  logic [CHK_W-1:0] r_word;
  logic             r_word_vld;
  logic [LEN_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_hs;
  logic             w_load;
  logic             w_add;
  logic             w_clear;
  logic [CHK_W-1:0] w_acc;

  // Holds s_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  assign s_ready = r_run & ((r_state == ST_IDLE) | (r_state == ST_ACC));
  assign w_hs    = s_valid & s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_add        = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_load       = 1'b1;
          w_state_next = s_last ? ST_FLUSH : ST_ACC;
        end
      end
      ST_ACC: begin
        w_add = r_word_vld;
        if (w_hs && s_last) begin
          w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_add        = r_word_vld;
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          w_clear      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Packer: a completed word sits in r_word for exactly one cycle while it is added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi       <= '0;
      r_hi_vld   <= 1'b0;
      r_word     <= '0;
      r_word_vld <= 1'b0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
    end else if (w_hs) begin
      if (r_state == ST_IDLE) begin
        r_cnt <= {{(LEN_W-1){1'b0}}, 1'b1};
        r_ovf <= 1'b0;
      end else if (r_cnt == '1) begin
        r_ovf <= 1'b1;
      end else begin
        r_cnt <= r_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
      end

      if (r_hi_vld && (r_state == ST_ACC)) begin
        r_word     <= {r_hi, s_data};
        r_word_vld <= 1'b1;
        r_hi_vld   <= 1'b0;
      end else if (s_last) begin
        r_word     <= {s_data, PAD_BYTE};
        r_word_vld <= 1'b1;
        r_hi_vld   <= 1'b0;
      end else begin
        r_hi       <= s_data;
        r_hi_vld   <= 1'b1;
        r_word_vld <= 1'b0;
      end
    end else begin
      r_word_vld <= 1'b0;
    end
  end

  chk_sum_acc u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_load  (w_load),
    .i_seed  (init_val),
    .i_add   (w_add),
    .i_word  (r_word),
    .o_acc   (w_acc)
  );

  assign res_valid = (r_state == ST_DONE);
  assign res_chk   = res_valid ? ~w_acc : '0;
  assign res_len   = r_cnt;
  assign res_ovf   = r_ovf;
  assign busy      = (r_state != ST_IDLE);

`ifdef CHK_SUM_CTRL_VERIFY_EN
  assign res_ok = res_valid & (w_acc == {CHK_W{1'b1}});
`endif

endmodule
